rgb_led_arbiter: RTL and testbench

Shares the board's single RGB LED among several requesters, such as status, error and heartbeat sources. Arbitration is round-robin with a minimum dwell time. The owner's colour is rendered through per-channel PWM on the active-low pico-ice LED pins. It sits between the application logic and the `led_red`/`led_green`/`led_blue` top-level pins, replacing direct LED drive.

---
 rtl/rgb_arb_pkg.sv | 30 +++
 rtl/rgb_pwm.sv | 52 +++++
 rtl/rgb_led_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_rgb_led_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_arb_pkg.sv
// Shared definitions for the RGB LED arbiter: FSM states, channel indices
// and a helper that extracts one requester's {r,g,b} slice from the packed colour bus.
package rgb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    localparam int MAX_REQ      = 8;
    localparam int MAX_PWM_BITS = 16;
    localparam int MAX_SLICE_W  = 3 * MAX_PWM_BITS;
    localparam int MAX_COLOR_W  = MAX_REQ * MAX_SLICE_W;

    // Callers zero-extend their colour bus to MAX_COLOR_W and truncate the result to their slice width.
    function automatic logic [MAX_SLICE_W-1:0] color_slice(
        input logic [MAX_COLOR_W-1:0] colors,
        input int                     idx,
        input int                     slice_w
    );
        logic [MAX_COLOR_W-1:0] shifted;
        shifted = colors >> (idx * slice_w);
        return shifted[MAX_SLICE_W-1:0];
    endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel PWM for the active-low RGB LED: free-running counter, duty shadows
// that only load at counter wrap, and registered pins that reset to off.
module rgb_pwm
    import rgb_arb_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3*PWM_BITS-1:0] load_color,
    output logic                  led_red,
    output logic                  led_green,
    output logic                  led_blue
);

    // Counter stops one short of all-ones so a duty of all-ones stays on for the whole period.
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

    logic [PWM_BITS-1:0]       cnt_q, cnt_d;
    logic [2:0][PWM_BITS-1:0]  duty_q, duty_d;
    logic [2:0]                pin_q, pin_d;
    logic                      wrap;

    always_comb begin
        wrap   = (cnt_q == CNT_LAST);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        duty_d = duty_q;
        if (wrap) begin
            duty_d = load_color;
        end
        pin_d[CH_R] = ~(cnt_q < duty_q[CH_R]);
        pin_d[CH_G] = ~(cnt_q < duty_q[CH_G]);
        pin_d[CH_B] = ~(cnt_q < duty_q[CH_B]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            duty_q <= '0;
            pin_q  <= '1;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pin_q  <= pin_d;
        end
    end

    assign led_red   = pin_q[CH_R];
    assign led_green = pin_q[CH_G];
    assign led_blue  = pin_q[CH_B];

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin owner selection with minimum dwell for the shared RGB LED.
// Optional idle blink is enabled by defining RGB_ARB_IDLE_BLINK_EN.
module rgb_led_arbiter
    import rgb_arb_pkg::*;
#(
    parameter int                       N_REQ        = 4,
    parameter int                       PWM_BITS     = 8,
    parameter int                       DWELL_CYCLES = 1_000_000,
    parameter int                       BLINK_DIV    = 50_000_000,
    parameter logic [3*PWM_BITS-1:0]    IDLE_COLOR   = 24'h000010
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*3*PWM_BITS-1:0] color,
    output logic [N_REQ-1:0]            grant,
    output logic                        led_red,
    output logic                        led_green,
    output logic                        led_blue
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int SLICE_W = 3 * PWM_BITS;
    localparam int DWELL_W = $clog2(DWELL_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;

    logic [N_REQ-1:0]    others;
    logic                owner_req;
    logic [IDX_W:0]      idle_pick;
    logic [IDX_W:0]      next_pick;
    logic [SLICE_W-1:0]  owner_rgb;
    logic [SLICE_W-1:0]  idle_color;
    logic [SLICE_W-1:0]  load_color;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

    // Returns {found, index}; scanning from the far end lets the closest match after start win.
    function automatic logic [IDX_W:0] find_from(
        input logic [N_REQ-1:0] pend,
        input logic [IDX_W-1:0] start
    );
        logic [IDX_W:0] res;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(start) + k) % N_REQ;
            if (pend[IDX_W'(j)]) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    always_comb begin
        others    = req & ~grant_q;
        owner_req = |(req & grant_q);
        idle_pick = find_from(req, rr_ptr_q);
        next_pick = find_from(others, wrap_inc(owner_q));
    end

    // A dropped request wins over dwell expiry; expiry with nobody waiting just holds the counter.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        dwell_d  = dwell_q;
        case (state_q)
            IDLE: begin
                if (idle_pick[IDX_W]) begin
                    state_d = OWN;
                    owner_d = idle_pick[IDX_W-1:0];
                    grant_d = onehot(idle_pick[IDX_W-1:0]);
                    dwell_d = '0;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    rr_ptr_d = wrap_inc(owner_q);
                    dwell_d  = '0;
                    if (next_pick[IDX_W]) begin
                        owner_d = next_pick[IDX_W-1:0];
                        grant_d = onehot(next_pick[IDX_W-1:0]);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (dwell_q == DWELL_LAST) begin
                    if (next_pick[IDX_W]) begin
                        owner_d = next_pick[IDX_W-1:0];
                        grant_d = onehot(next_pick[IDX_W-1:0]);
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            dwell_q  <= dwell_d;
        end
    end

`ifdef RGB_ARB_IDLE_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    // Held at zero while owned so every visit to IDLE starts with a dark half-period.
    always_comb begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        if (state_q == IDLE) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 1'b1;
                blink_phase_d = blink_phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign idle_color = blink_phase_q ? IDLE_COLOR : '0;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^{IDLE_COLOR, BLINK_DIV};
    assign idle_color       = '0;
`endif

    assign owner_rgb  = SLICE_W'(color_slice(MAX_COLOR_W'(color), int'(owner_q), SLICE_W));
    assign load_color = (grant_q != '0) ? owner_rgb : idle_color;
    assign grant      = grant_q;

    rgb_pwm #(
        .PWM_BITS   (PWM_BITS)
    ) u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_color (load_color),
        .led_red    (led_red),
        .led_green  (led_green),
        .led_blue   (led_blue)
    );

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Self-checking bench for rgb_led_arbiter: grant table, pin duty windows, async reset,
// idle behaviour and randomized traffic against a behavioural model.
module tb_rgb_led_arbiter;

    localparam int          N_REQ        = 4;
    localparam int          PWM_BITS     = 4;
    localparam int          DWELL_CYCLES = 20;
    localparam int          BLINK_DIV    = 8;
    localparam logic [11:0] IDLE_COLOR   = 12'h00F;
    localparam int          PERIOD       = 15;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req   = '0;
    logic [47:0] color = '0;
    logic [3:0]  grant;
    logic        led_red, led_green, led_blue;

    always #5 clk = ~clk;

    rgb_led_arbiter #(
        .N_REQ        (N_REQ),
        .PWM_BITS     (PWM_BITS),
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLINK_DIV    (BLINK_DIV),
        .IDLE_COLOR   (IDLE_COLOR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .color     (color),
        .grant     (grant),
        .led_red   (led_red),
        .led_green (led_green),
        .led_blue  (led_blue)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: owner as an integer (-1 = nobody), duties/pins indexed r=2,g=1,b=0.
    int m_owner, m_rr, m_dwell, m_cnt, m_bc;
    bit m_phase;
    int m_duty [3];
    bit m_pin  [3];

    typedef struct {
        logic [3:0] req;
        int         cycles;
        logic [3:0] exp_grant;
    } vec_t;

    vec_t vecs [12];

    function automatic int color_of(int i, int ch);
        logic [47:0] s;
        s = color >> (i * 12 + ch * 4);
        return int'(s[3:0]);
    endfunction

    function automatic int next_pending(int from, int exclude);
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (from + k) % N_REQ;
            if (j != exclude && req[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_dwell = 0; m_cnt = 0; m_bc = 0; m_phase = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_duty[c] = 0;
            m_pin[c]  = 1'b1;
        end
    endtask

    task automatic model_edge();
        bit new_pin [3];
        int ld [3];
        int nxt;
        for (int c = 0; c < 3; c++) begin
            new_pin[c] = !(m_cnt < m_duty[c]);
            ld[c] = 0;
            if (m_owner >= 0) ld[c] = color_of(m_owner, c);
`ifdef RGB_ARB_IDLE_BLINK_EN
            else if (m_phase) ld[c] = (IDLE_COLOR >> (c * 4)) & 12'hF;
`endif
        end
        if (m_cnt == PERIOD - 1) begin
            m_cnt = 0;
            for (int c = 0; c < 3; c++) m_duty[c] = ld[c];
        end else begin
            m_cnt++;
        end
`ifdef RGB_ARB_IDLE_BLINK_EN
        if (m_owner < 0) begin
            if (m_bc == BLINK_DIV - 1) begin m_bc = 0; m_phase = !m_phase; end
            else m_bc++;
        end else begin
            m_bc = 0; m_phase = 1'b0;
        end
`endif
        if (m_owner < 0) begin
            nxt = next_pending(m_rr, -1);
            if (nxt >= 0) begin m_owner = nxt; m_dwell = 0; end
        end else if (!req[m_owner]) begin
            m_rr    = (m_owner + 1) % N_REQ;
            m_owner = next_pending((m_owner + 1) % N_REQ, m_owner);
            m_dwell = 0;
        end else if (m_dwell == DWELL_CYCLES - 1) begin
            nxt = next_pending((m_owner + 1) % N_REQ, m_owner);
            if (nxt >= 0) begin m_owner = nxt; m_dwell = 0; end
        end else begin
            m_dwell++;
        end
        for (int c = 0; c < 3; c++) m_pin[c] = new_pin[c];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req_v, input logic [47:0] color_v);
        req   = req_v;
        color = color_v;
    endtask

    // One clock: advance the model with the DUT, then compare just after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        checkOutput("model_grant", {28'b0, grant}, {28'b0, exp_grant()});
        checkOutput("model_pins", {29'b0, led_red, led_green, led_blue},
                    {29'b0, m_pin[2], m_pin[1], m_pin[0]});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int red_low, green_low, blue_low;

        vecs[0]  = '{4'b0101,  1, 4'b0001};
        vecs[1]  = '{4'b0101, 19, 4'b0001};
        vecs[2]  = '{4'b0101,  1, 4'b0100};
        vecs[3]  = '{4'b0101, 19, 4'b0100};
        vecs[4]  = '{4'b0101,  1, 4'b0001};
        vecs[5]  = '{4'b0100,  1, 4'b0100};
        vecs[6]  = '{4'b0000,  1, 4'b0000};
        vecs[7]  = '{4'b1010,  1, 4'b1000};
        vecs[8]  = '{4'b0010,  1, 4'b0010};
        vecs[9]  = '{4'b0010, 30, 4'b0010};
        vecs[10] = '{4'b0011,  1, 4'b0001};
        vecs[11] = '{4'b0000,  1, 4'b0000};

        model_reset();
        applyStimulus(4'b0000, '0);
        rst_n = 1'b0;
        ticks(3);
        checkOutput("reset_grant", {28'b0, grant}, 32'h0);
        checkOutput("reset_pins", {29'b0, led_red, led_green, led_blue}, 32'h7);
        rst_n = 1'b1;
        ticks(4);
        checkOutput("post_reset_grant", {28'b0, grant}, 32'h0);
        checkOutput("post_reset_pins", {29'b0, led_red, led_green, led_blue}, 32'h7);

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].req, '0);
            ticks(vecs[v].cycles);
            checkOutput($sformatf("table_grant_%0d", v), {28'b0, grant}, {28'b0, vecs[v].exp_grant});
        end

        applyStimulus(4'b0001, {36'h0, 12'hF08});
        tick();
        checkOutput("single_grant", {28'b0, grant}, 32'h1);
        ticks(2 * PERIOD + 2);
        red_low = 0; green_low = 0; blue_low = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            if (!led_red)   red_low++;
            if (!led_green) green_low++;
            if (!led_blue)  blue_low++;
        end
        checkOutput("red_low_cycles", red_low, PERIOD);
        checkOutput("green_low_cycles", green_low, 0);
        checkOutput("blue_low_cycles", blue_low, 8);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_grant", {28'b0, grant}, 32'h0);
        checkOutput("async_reset_pins", {29'b0, led_red, led_green, led_blue}, 32'h7);
        model_reset();
        ticks(2);
        rst_n = 1'b1;
        tick();
        checkOutput("restart_grant", {28'b0, grant}, 32'h1);

        applyStimulus(4'b0000, {36'h0, 12'hF08});
        tick();
        checkOutput("drop_all_grant", {28'b0, grant}, 32'h0);
        ticks(PERIOD + 2);
`ifndef RGB_ARB_IDLE_BLINK_EN
        blue_low = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            tick();
            if (!led_blue) blue_low++;
        end
        checkOutput("idle_blue_dark", blue_low, 0);
        checkOutput("idle_pins", {29'b0, led_red, led_green, led_blue}, 32'h7);
`else
        ticks(6 * PERIOD);
`endif

        for (int i = 0; i < 800; i++) begin
            logic [3:0]  r;
            logic [47:0] c;
            r = req;
            c = color;
            if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) c = {16'($urandom), 32'($urandom)};
            applyStimulus(r, c);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
